branch_commit_queue: RTL and testbench
======================================

Name: branch_commit_queue

Overview:
- In-order tracking queue for predicted conditional branches, sitting between issue/ALU resolution and the BHT predictor's update port.
- Records each branch's PC and predicted direction at allocation, accepts out-of-order resolution by tag, and retires in program order.
- At retirement, emits exactly one update pulse (pc, taken) to the predictor. On a misprediction it drives a redirect and self-flushes.

Parameters:
- DEPTH, 8, number of branch entries; must be a power of two, at least 2.
- TAG_W, 3, log2(DEPTH); width of entry tags and pointers.
- ADDR_W, 32, PC width.

Ports:
- clk  in  1  system clock
- rst_in  in  1  asynchronous reset, active-low
- rdy_in  in  1  global ready; low pauses the block
- alloc_en  in  1  allocate a branch entry this cycle
- alloc_pc  in  ADDR_W  PC of the allocated branch
- alloc_pred  in  1  predicted taken bit, as sampled from the predictor's jump output
- alloc_tag  out  TAG_W  tag given to the allocation; combinational, equal to the tail pointer
- full  out  1  combinational; high when count==DEPTH
- res_en  in  1  resolution valid
- res_tag  in  TAG_W  entry being resolved
- res_jump  in  1  actual taken bit
- res_target  in  ADDR_W  actual taken target
- rob_in_en  out  1  registered predictor-update pulse
- rob_ain  out  ADDR_W  registered PC of the retired branch
- rob_jump  out  1  registered actual direction of the retired branch
- mispredict  out  1  registered one-cycle redirect pulse
- redirect_pc  out  ADDR_W  registered correct next PC; valid while mispredict=1
- stat_branches  out  32  count of retired branches
- stat_mispredicts  out  32  count of retired mispredicted branches

Behaviour:
- Reset (rst_in=0, asynchronous):
  - head, tail and count go to 0; all valid and resolved bits go to 0.
  - All registered outputs and both stat counters go to 0.
  - Reset asserted mid-operation discards every entry immediately.
- Per-entry state: valid, resolved, pc, pred, actual, target.
- Pause (rdy_in=0 at an edge):
  - No state changes.
  - rob_in_en and mispredict are cleared to 0 at that edge; rob_ain, rob_jump and redirect_pc hold.
- Allocate (alloc_en && !full):
  - Write pc and pred at tail; set valid, clear resolved.
  - tail <= tail+1, wrapping mod DEPTH.
  - alloc_en while full is ignored; no bypass against a same-cycle retire.
- Resolve (res_en):
  - If entry[res_tag].valid, set resolved and store actual and target.
  - Resolving an invalid entry is ignored, including a tag being allocated in the same cycle.
  - Re-resolving an already resolved entry overwrites its actual and target.
- Retire (head valid && resolved, evaluated on pre-edge state), at most one per cycle:
  - rob_in_en<=1, rob_ain<=pc, rob_jump<=actual.
  - Clear valid at head; head<=head+1; stat_branches increments, wrapping.
  - Latency: a resolve captured at edge N retires at edge N+1, so rob_in_en is high in the cycle after N+1.
  - With no retire, rob_in_en<=0 and mispredict<=0.
- Mispredict (retiring entry with pred!=actual):
  - mispredict<=1 and stat_mispredicts increments.
  - redirect_pc <= actual ? target : pc+4, computed modulo 2^ADDR_W.
  - At the same edge, clear all valid bits and set head=tail=count=0.
  - A same-cycle allocate and a same-cycle resolve are both dropped; flush wins.
- Count update: count += (alloc accepted) - (retire). A simultaneous allocate and retire leaves count unchanged.
- Pointers wrap mod DEPTH. count ranges over 0..DEPTH and needs TAG_W+1 bits.

Test Plan:
- Reset, then allocate pc=0x100 pred=1 (tag 0); resolve tag 0 jump=1 target=0x200 -> next cycle rob_in_en=1, rob_ain=0x100, rob_jump=1, mispredict=0, stat_branches=1.
- Allocate tags 0,1,2 (pcs 0x10, 0x14, 0x18, pred=0); resolve in order 2,1,0, all jump=0 -> nothing retires until tag 0 resolves. Then three consecutive rob_in_en pulses with pcs 0x10, 0x14, 0x18.
- Allocate pc=0x40 pred=1 and pc=0x44; resolve tag 0 jump=0 -> mispredict=1, redirect_pc=0x44, rob_jump=0. Next cycle full=0, alloc_tag=0, and the stale tag-1 entry never retires.
- Allocate 8 entries -> full=1 and a ninth alloc_en is ignored. Retire one -> full=0, and the next allocation gets tag 0 (wrap).
- Hold rdy_in=0 with a resolved head -> no rob_in_en and state held. Raise rdy_in -> retire on the following edge.
- Assert rst_in=0 between clock edges with 3 entries live -> all outputs 0 immediately. After release, the first allocation gets tag 0.

Source files
------------

// File: rtl/branch_commit_queue.sv
// branch_commit_queue: in-order tracking queue for predicted conditional branches.
// Entries are allocated at issue, resolved out of order by tag, and retired in
// program order. Each retirement emits one predictor-update pulse; a retiring
// mispredicted branch raises a redirect and flushes every entry.

module branch_commit_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned TAG_W  = 3,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_in,
   input  logic              rdy_in,
   // allocation
   input  logic              alloc_en,
   input  logic [ADDR_W-1:0] alloc_pc,
   input  logic              alloc_pred,
   output logic [TAG_W-1:0]  alloc_tag,
   output logic              full,
   // resolution
   input  logic              res_en,
   input  logic [TAG_W-1:0]  res_tag,
   input  logic              res_jump,
   input  logic [ADDR_W-1:0] res_target,
   // predictor update
   output logic              rob_in_en,
   output logic [ADDR_W-1:0] rob_ain,
   output logic              rob_jump,
   // redirect
   output logic              mispredict,
   output logic [ADDR_W-1:0] redirect_pc,
   // statistics
   output logic [31:0]       stat_branches,
   output logic [31:0]       stat_mispredicts
);

   localparam logic [TAG_W:0]  LP_FULL_COUNT = (TAG_W + 1)'(DEPTH);
   localparam logic [TAG_W-1:0] LP_PTR_ONE   = TAG_W'(1);
   localparam logic [TAG_W:0]  LP_CNT_ONE    = (TAG_W + 1)'(1);
   localparam logic [ADDR_W-1:0] LP_PC_STEP  = ADDR_W'(4);

   // Queue control state
   logic [TAG_W-1:0]  r_head;
   logic [TAG_W-1:0]  r_tail;
   logic [TAG_W:0]    r_count;
   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  r_resolved;

   // Per-entry payload
   logic [ADDR_W-1:0] r_pc     [DEPTH];
   logic              r_pred   [DEPTH];
   logic              r_actual [DEPTH];
   logic [ADDR_W-1:0] r_target [DEPTH];

   // Registered outputs
   logic              r_rob_in_en;
   logic [ADDR_W-1:0] r_rob_ain;
   logic              r_rob_jump;
   logic              r_mispredict;
   logic [ADDR_W-1:0] r_redirect_pc;
   logic [31:0]       r_stat_branches;
   logic [31:0]       r_stat_mispredicts;

   // Next-state and decode wires
   logic [TAG_W-1:0]  w_head_d;
   logic [TAG_W-1:0]  w_tail_d;
   logic [TAG_W:0]    w_count_d;
   logic [DEPTH-1:0]  w_valid_d;
   logic [DEPTH-1:0]  w_resolved_d;
   logic              w_full;
   logic              w_alloc;
   logic              w_res_hit;
   logic              w_retire;
   logic              w_mispred;
   logic [ADDR_W-1:0] w_head_pc;
   logic              w_head_actual;
   logic [ADDR_W-1:0] w_redirect;

   assign w_full    = (r_count == LP_FULL_COUNT);
   assign alloc_tag = r_tail;
   assign full      = w_full;

   // Decode this cycle's events from pre-edge state; a tag being allocated
   // now is still invalid, so a same-cycle resolve of it is dropped.
   always_comb begin
      w_alloc       = alloc_en && !w_full;
      w_res_hit     = res_en && r_valid[res_tag];
      w_retire      = r_valid[r_head] && r_resolved[r_head];
      w_mispred     = w_retire && (r_pred[r_head] != r_actual[r_head]);
      w_head_pc     = r_pc[r_head];
      w_head_actual = r_actual[r_head];
      w_redirect    = w_head_actual ? r_target[r_head] : (w_head_pc + LP_PC_STEP);
   end

   // Next-state for pointers, count and entry flags; a flush overrides
   // any same-cycle allocate or resolve.
   always_comb begin
      w_head_d     = r_head;
      w_tail_d     = r_tail;
      w_count_d    = r_count;
      w_valid_d    = r_valid;
      w_resolved_d = r_resolved;
      if (rdy_in) begin
         if (w_mispred) begin
            w_head_d     = '0;
            w_tail_d     = '0;
            w_count_d    = '0;
            w_valid_d    = '0;
            w_resolved_d = '0;
         end else begin
            if (w_retire) begin
               w_valid_d[r_head] = 1'b0;
               w_head_d          = r_head + LP_PTR_ONE;
            end
            if (w_alloc) begin
               w_valid_d[r_tail]    = 1'b1;
               w_resolved_d[r_tail] = 1'b0;
               w_tail_d             = r_tail + LP_PTR_ONE;
            end
            if (w_res_hit) begin
               w_resolved_d[res_tag] = 1'b1;
            end
            unique case ({w_alloc, w_retire})
               2'b10:   w_count_d = r_count + LP_CNT_ONE;
               2'b01:   w_count_d = r_count - LP_CNT_ONE;
               default: w_count_d = r_count;
            endcase
         end
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_valid    <= '0;
         r_resolved <= '0;
      end else begin
         r_head     <= w_head_d;
         r_tail     <= w_tail_d;
         r_count    <= w_count_d;
         r_valid    <= w_valid_d;
         r_resolved <= w_resolved_d;
      end
   end

   // Entry payload capture on allocate and resolve
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_pc     <= '{default: '0};
         r_pred   <= '{default: 1'b0};
         r_actual <= '{default: 1'b0};
         r_target <= '{default: '0};
      end else if (rdy_in && !w_mispred) begin
         if (w_alloc) begin
            r_pc[r_tail]   <= alloc_pc;
            r_pred[r_tail] <= alloc_pred;
         end
         if (w_res_hit) begin
            r_actual[res_tag] <= res_jump;
            r_target[res_tag] <= res_target;
         end
      end
   end

   // Retirement outputs: update pulse, redirect and statistics. A pause
   // drops both pulses but holds the data outputs.
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_rob_in_en        <= 1'b0;
         r_rob_ain          <= '0;
         r_rob_jump         <= 1'b0;
         r_mispredict       <= 1'b0;
         r_redirect_pc      <= '0;
         r_stat_branches    <= '0;
         r_stat_mispredicts <= '0;
      end else if (!rdy_in) begin
         r_rob_in_en  <= 1'b0;
         r_mispredict <= 1'b0;
      end else begin
         r_rob_in_en  <= w_retire;
         r_mispredict <= w_mispred;
         if (w_retire) begin
            r_rob_ain       <= w_head_pc;
            r_rob_jump      <= w_head_actual;
            r_stat_branches <= r_stat_branches + 32'd1;
         end
         if (w_mispred) begin
            r_redirect_pc      <= w_redirect;
            r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
         end
      end
   end

   assign rob_in_en        = r_rob_in_en;
   assign rob_ain          = r_rob_ain;
   assign rob_jump         = r_rob_jump;
   assign mispredict       = r_mispredict;
   assign redirect_pc      = r_redirect_pc;
   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_commit_queue.sv
// Self-checking bench for branch_commit_queue. Expected retirements are queued
// as stimulus is driven and checked by a monitor whenever rob_in_en is seen.

module tb_branch_commit_queue;

   localparam int DEPTH  = 8;
   localparam int TAG_W  = 3;
   localparam int ADDR_W = 32;

   typedef struct {
      logic [31:0] pc;
      logic        jump;
      logic        mis;
      logic [31:0] redir;
   } exp_t;

   logic              clk;
   logic              rst_in;
   logic              rdy_in;
   logic              alloc_en;
   logic [ADDR_W-1:0] alloc_pc;
   logic              alloc_pred;
   logic [TAG_W-1:0]  alloc_tag;
   logic              full;
   logic              res_en;
   logic [TAG_W-1:0]  res_tag;
   logic              res_jump;
   logic [ADDR_W-1:0] res_target;
   logic              rob_in_en;
   logic [ADDR_W-1:0] rob_ain;
   logic              rob_jump;
   logic              mispredict;
   logic [ADDR_W-1:0] redirect_pc;
   logic [31:0]       stat_branches;
   logic [31:0]       stat_mispredicts;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   branch_commit_queue #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W),
      .ADDR_W(ADDR_W)
   ) u_dut (
      .clk             (clk),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .alloc_en        (alloc_en),
      .alloc_pc        (alloc_pc),
      .alloc_pred      (alloc_pred),
      .alloc_tag       (alloc_tag),
      .full            (full),
      .res_en          (res_en),
      .res_tag         (res_tag),
      .res_jump        (res_jump),
      .res_target      (res_target),
      .rob_in_en       (rob_in_en),
      .rob_ain         (rob_ain),
      .rob_jump        (rob_jump),
      .mispredict      (mispredict),
      .redirect_pc     (redirect_pc),
      .stat_branches   (stat_branches),
      .stat_mispredicts(stat_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
      $fatal(1, "watchdog");
   end

   // Monitor: every update pulse must match the oldest expected retirement.
   always @(negedge clk) begin
      exp_t e;
      if (rst_in === 1'b1) begin
         if (rob_in_en === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_retire: rob_ain=%h rob_jump=%b, none expected",
                        rob_ain, rob_jump);
            end else begin
               e = exp_q.pop_front();
               if (rob_ain !== e.pc || rob_jump !== e.jump || mispredict !== e.mis ||
                   (e.mis && redirect_pc !== e.redir)) begin
                  n_fail++;
                  $display("FAIL retire: got pc=%h jump=%b mis=%b redir=%h, want pc=%h jump=%b mis=%b redir=%h",
                           rob_ain, rob_jump, mispredict, redirect_pc,
                           e.pc, e.jump, e.mis, e.redir);
               end
            end
         end else if (mispredict === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL mispredict_without_retire: mispredict=1 while rob_in_en=0");
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic jump, input logic mis,
                           input logic [31:0] redir);
      exp_t e;
      e.pc    = pc;
      e.jump  = jump;
      e.mis   = mis;
      e.redir = redir;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      tick();
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_retires: %0d outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
      rst_in = 1'b1;
   endtask

   task automatic do_alloc(input logic [31:0] pc, input logic pred, input logic [2:0] want_tag);
      alloc_en   = 1'b1;
      alloc_pc   = pc;
      alloc_pred = pred;
      chk("alloc_tag", 32'(alloc_tag), 32'(want_tag));
      tick();
      alloc_en = 1'b0;
   endtask

   task automatic do_resolve(input logic [2:0] tag, input logic jump, input logic [31:0] tgt);
      res_en     = 1'b1;
      res_tag    = tag;
      res_jump   = jump;
      res_target = tgt;
      tick();
      res_en = 1'b0;
   endtask

   task automatic drain(input int budget);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < budget) begin
         tick();
         cyc++;
      end
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d retires outstanding, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      do_reset();
      chk("reset_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_rob_in_en", 32'(rob_in_en), 32'd0);
      chk("reset_mispredict", 32'(mispredict), 32'd0);
      chk("reset_rob_ain", rob_ain, 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      chk("reset_stat_branches", stat_branches, 32'd0);
      chk("reset_stat_mispredicts", stat_mispredicts, 32'd0);
   endtask

   task automatic test_single();
      do_reset();
      do_alloc(32'h100, 1'b1, 3'd0);
      push_exp(32'h100, 1'b1, 1'b0, 32'h0);
      do_resolve(3'd0, 1'b1, 32'h200);
      chk("single_no_early_retire", 32'(rob_in_en), 32'd0);
      tick();
      chk("single_rob_in_en", 32'(rob_in_en), 32'd1);
      chk("single_mispredict", 32'(mispredict), 32'd0);
      chk("single_stat_branches", stat_branches, 32'd1);
      tick();
      chk("single_pulse_one_cycle", 32'(rob_in_en), 32'd0);
   endtask

   task automatic test_out_of_order();
      do_reset();
      do_alloc(32'h10, 1'b0, 3'd0);
      do_alloc(32'h14, 1'b0, 3'd1);
      do_alloc(32'h18, 1'b0, 3'd2);
      do_resolve(3'd2, 1'b0, 32'h0);
      tick();
      chk("ooo_hold_after_tag2", 32'(rob_in_en), 32'd0);
      do_resolve(3'd1, 1'b0, 32'h0);
      tick();
      chk("ooo_hold_after_tag1", 32'(rob_in_en), 32'd0);
      push_exp(32'h10, 1'b0, 1'b0, 32'h0);
      push_exp(32'h14, 1'b0, 1'b0, 32'h0);
      push_exp(32'h18, 1'b0, 1'b0, 32'h0);
      do_resolve(3'd0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ooo_consecutive_pulse", 32'(rob_in_en), 32'd1);
      end
      drain(4);
      chk("ooo_stat_branches", stat_branches, 32'd3);
   endtask

   task automatic test_mispredict();
      do_reset();
      do_alloc(32'h40, 1'b1, 3'd0);
      do_alloc(32'h44, 1'b0, 3'd1);
      do_resolve(3'd1, 1'b0, 32'h0);
      push_exp(32'h40, 1'b0, 1'b1, 32'h44);
      res_en     = 1'b1;
      res_tag    = 3'd0;
      res_jump   = 1'b0;
      res_target = 32'h0;
      tick();
      res_en = 1'b0;
      // allocate during the flushing edge; the flush must drop it
      alloc_en   = 1'b1;
      alloc_pc   = 32'h90;
      alloc_pred = 1'b0;
      tick();
      alloc_en = 1'b0;
      chk("mis_mispredict", 32'(mispredict), 32'd1);
      chk("mis_redirect_pc", redirect_pc, 32'h44);
      chk("mis_rob_jump", 32'(rob_jump), 32'd0);
      chk("mis_stat_mispredicts", stat_mispredicts, 32'd1);
      tick();
      chk("mis_full_after_flush", 32'(full), 32'd0);
      chk("mis_alloc_tag_after_flush", 32'(alloc_tag), 32'd0);
      chk("mis_pulse_one_cycle", 32'(mispredict), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      // taken mispredict redirects to the resolved target
      do_alloc(32'h80, 1'b0, 3'd0);
      push_exp(32'h80, 1'b1, 1'b1, 32'h300);
      do_resolve(3'd0, 1'b1, 32'h300);
      drain(4);
      chk("mis_stat_mispredicts_2", stat_mispredicts, 32'd2);
      chk("mis_stat_branches", stat_branches, 32'd2);
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_alloc(32'h1000 + 32'(4 * i), 1'b0, 3'(i));
      chk("full_after_8", 32'(full), 32'd1);
      alloc_en   = 1'b1;
      alloc_pc   = 32'hdead;
      alloc_pred = 1'b0;
      tick();
      alloc_en = 1'b0;
      chk("full_ninth_ignored", 32'(full), 32'd1);
      chk("full_tail_held", 32'(alloc_tag), 32'd0);
      push_exp(32'h1000, 1'b0, 1'b0, 32'h0);
      do_resolve(3'd0, 1'b0, 32'h0);
      tick();
      chk("full_retire_pulse", 32'(rob_in_en), 32'd1);
      chk("full_cleared", 32'(full), 32'd0);
      do_alloc(32'h2000, 1'b0, 3'd0);
      chk("full_again", 32'(full), 32'd1);
      for (int i = 1; i < DEPTH; i++) begin
         push_exp(32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
         do_resolve(3'(i), 1'b0, 32'h0);
      end
      push_exp(32'h2000, 1'b0, 1'b0, 32'h0);
      do_resolve(3'd0, 1'b0, 32'h0);
      drain(12);
      chk("full_stat_branches", stat_branches, 32'd9);
   endtask

   task automatic test_pause();
      do_reset();
      do_alloc(32'h500, 1'b1, 3'd0);
      push_exp(32'h500, 1'b1, 1'b0, 32'h0);
      res_en     = 1'b1;
      res_tag    = 3'd0;
      res_jump   = 1'b1;
      res_target = 32'h700;
      tick();
      res_en = 1'b0;
      rdy_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         alloc_en   = 1'b1;
         alloc_pc   = 32'h5ff;
         alloc_pred = 1'b0;
         tick();
         chk("pause_no_retire", 32'(rob_in_en), 32'd0);
         chk("pause_tail_held", 32'(alloc_tag), 32'd1);
      end
      alloc_en = 1'b0;
      chk("pause_stat_held", stat_branches, 32'd0);
      rdy_in = 1'b1;
      tick();
      chk("pause_resume_retire", 32'(rob_in_en), 32'd1);
      chk("pause_resume_stat", stat_branches, 32'd1);
      rdy_in = 1'b0;
      tick();
      chk("pause_clears_pulse", 32'(rob_in_en), 32'd0);
      chk("pause_holds_rob_ain", rob_ain, 32'h500);
      rdy_in = 1'b1;
   endtask

   task automatic test_async_reset();
      do_reset();
      do_alloc(32'h600, 1'b0, 3'd0);
      push_exp(32'h600, 1'b0, 1'b0, 32'h0);
      do_resolve(3'd0, 1'b0, 32'h0);
      tick();
      do_alloc(32'h604, 1'b0, 3'd1);
      do_alloc(32'h608, 1'b0, 3'd2);
      do_alloc(32'h60c, 1'b0, 3'd3);
      do_resolve(3'd2, 1'b0, 32'h0);
      chk("areset_pre_stat", stat_branches, 32'd1);
      @(posedge clk);
      #2;
      rst_in = 1'b0;
      #1;
      chk("areset_stat_branches", stat_branches, 32'd0);
      chk("areset_alloc_tag", 32'(alloc_tag), 32'd0);
      chk("areset_rob_ain", rob_ain, 32'd0);
      chk("areset_rob_in_en", 32'(rob_in_en), 32'd0);
      chk("areset_full", 32'(full), 32'd0);
      tick();
      rst_in = 1'b1;
      do_alloc(32'h700, 1'b0, 3'd0);
      do_resolve(3'd2, 1'b0, 32'h0);
      tick();
      tick();
      chk("areset_stale_tag_ignored", 32'(rob_in_en), 32'd0);
      push_exp(32'h700, 1'b0, 1'b0, 32'h0);
      do_resolve(3'd0, 1'b0, 32'h0);
      drain(4);
   endtask

   initial begin
      rst_in     = 1'b0;
      rdy_in     = 1'b1;
      alloc_en   = 1'b0;
      alloc_pc   = '0;
      alloc_pred = 1'b0;
      res_en     = 1'b0;
      res_tag    = '0;
      res_jump   = 1'b0;
      res_target = '0;
      test_reset();
      test_single();
      test_out_of_order();
      test_mispredict();
      test_full_wrap();
      test_pause();
      test_async_reset();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
